// File: rtl/nested_loop_counter.sv
// N-deep nested loop counter: per-level bound and count mode (wrap-up, down, bounce),
// levels chained by carry, launched with start_i and reporting completion on done_o.
module nested_loop_counter #(
    parameter int NUM_LOOPS = 3,
    parameter int WIDTH     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       start_i,
    input  logic                       en_i,
    input  logic [NUM_LOOPS*WIDTH-1:0] bound_i,
    input  logic [2*NUM_LOOPS-1:0]     mode_i,
    output logic [NUM_LOOPS*WIDTH-1:0] idx_o,
    output logic [NUM_LOOPS-1:0]       last_o,
    output logic                       busy_o,
    output logic                       done_o
);

    // Handshake: start_i is taken only in IDLE; busy_o stays high for the whole run;
    // done_o pulses for one cycle after the step where every level was terminal.
    // A start_i on the done_o cycle launches the next run with no extra bubble.
    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

    state_e               state_q;
    logic [WIDTH-1:0]     idx_q   [NUM_LOOPS];
    logic [WIDTH-1:0]     bnd_q   [NUM_LOOPS];
    logic [1:0]           mode_q  [NUM_LOOPS];
    logic [NUM_LOOPS-1:0] dir_dn_q;
    logic                 done_q;

    logic [NUM_LOOPS-1:0] term;
    logic [NUM_LOOPS-1:0] step;
    logic [WIDTH-1:0]     idx_nxt [NUM_LOOPS];
    logic [NUM_LOOPS-1:0] dir_nxt;
    logic                 final_step;
    logic                 carry;

    function automatic logic [WIDTH-1:0] init_val(input logic [1:0] m, input logic [WIDTH-1:0] b);
        return (m == MODE_DOWN) ? b : '0;
    endfunction

    always_comb begin
        term = '0;
        for (int k = 0; k < NUM_LOOPS; k++) begin
            case (mode_q[k])
                MODE_DOWN:   term[k] = (idx_q[k] == '0);
                MODE_BOUNCE: term[k] = (dir_dn_q[k] && idx_q[k] == '0) || (bnd_q[k] == '0);
                default:     term[k] = (idx_q[k] == bnd_q[k]);
            endcase
        end
    end

    // A level steps only when every inner level is terminal on the same en_i cycle.
    always_comb begin
        step  = '0;
        carry = (state_q == RUN) && en_i;
        for (int k = 0; k < NUM_LOOPS; k++) begin
            step[k] = carry;
            carry   = carry && term[k];
        end
        final_step = carry;
    end

    always_comb begin
        for (int k = 0; k < NUM_LOOPS; k++) begin
            idx_nxt[k] = idx_q[k];
            dir_nxt[k] = dir_dn_q[k];
            if (term[k]) begin
                idx_nxt[k] = init_val(mode_q[k], bnd_q[k]);
                dir_nxt[k] = 1'b0;
            end else begin
                case (mode_q[k])
                    MODE_DOWN: idx_nxt[k] = idx_q[k] - 1'b1;
                    MODE_BOUNCE: begin
                        // The turn at B flips direction and descends in the same step, so B is visited once.
                        if (dir_dn_q[k] || idx_q[k] == bnd_q[k]) begin
                            idx_nxt[k] = idx_q[k] - 1'b1;
                            dir_nxt[k] = 1'b1;
                        end else begin
                            idx_nxt[k] = idx_q[k] + 1'b1;
                        end
                    end
                    default: idx_nxt[k] = idx_q[k] + 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            dir_dn_q <= '0;
            for (int k = 0; k < NUM_LOOPS; k++) begin
                idx_q[k]  <= '0;
                bnd_q[k]  <= '0;
                mode_q[k] <= '0;
            end
        end else if (clear_i) begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            dir_dn_q <= '0;
            for (int k = 0; k < NUM_LOOPS; k++) idx_q[k] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q  <= RUN;
                        dir_dn_q <= '0;
                        for (int k = 0; k < NUM_LOOPS; k++) begin
                            bnd_q[k]  <= bound_i[k*WIDTH +: WIDTH];
                            mode_q[k] <= mode_i[2*k +: 2];
                            idx_q[k]  <= init_val(mode_i[2*k +: 2], bound_i[k*WIDTH +: WIDTH]);
                        end
                    end
                end
                RUN: begin
                    for (int k = 0; k < NUM_LOOPS; k++) begin
                        if (step[k]) begin
                            idx_q[k]    <= idx_nxt[k];
                            dir_dn_q[k] <= dir_nxt[k];
                        end
                    end
                    if (final_step) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        idx_o = '0;
        for (int k = 0; k < NUM_LOOPS; k++) idx_o[k*WIDTH +: WIDTH] = idx_q[k];
    end

    assign busy_o = (state_q == RUN);
    assign last_o = term & {NUM_LOOPS{busy_o}};
    assign done_o = done_q;

endmodule

// File: tb/tb_nested_loop_counter.sv
// Bench for nested_loop_counter: a mixed-radix iteration model checked every cycle,
// plus directed scenarios with hand-computed index traces and step counts.
module tb_nested_loop_counter;

    localparam int NL = 3;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b1;
    logic            clear_i = 1'b0;
    logic            start_i = 1'b0;
    logic            en_i = 1'b0;
    logic [NL*W-1:0] bound_i = '0;
    logic [2*NL-1:0] mode_i = '0;
    logic [NL*W-1:0] idx_o;
    logic [NL-1:0]   last_o;
    logic            busy_o;
    logic            done_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [NL*W-1:0] trace[$];
    logic [NL-1:0]   ltrace[$];
    logic [NL*W-1:0] exp_q[$];

    nested_loop_counter #(.NUM_LOOPS(NL), .WIDTH(W)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i), .en_i(en_i),
        .bound_i(bound_i), .mode_i(mode_i), .idx_o(idx_o), .last_o(last_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: a run is a step counter n over the product of per-level visit sequences
    function automatic int seq_len(input int m, input int b);
        return (m == 2) ? 2 * b + 1 : b + 1;
    endfunction

    function automatic int seq_val(input int m, input int b, input int p);
        if (m == 1) return b - p;
        if (m == 2) return (p <= b) ? p : 2 * b - p;
        return p;
    endfunction

    int m_bnd[NL];
    int m_mode[NL];
    int m_idle[NL];
    int m_n;
    bit m_busy;
    bit m_done;

    function automatic int m_total();
        int t = 1;
        for (int k = 0; k < NL; k++) t = t * seq_len(m_mode[k], m_bnd[k]);
        return t;
    endfunction

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_n <= 0;
            for (int k = 0; k < NL; k++) begin
                m_idle[k] <= 0; m_bnd[k] <= 0; m_mode[k] <= 0;
            end
        end else if (clear_i) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_n <= 0;
            for (int k = 0; k < NL; k++) m_idle[k] <= 0;
        end else if (!m_busy) begin
            m_done <= 1'b0;
            if (start_i) begin
                m_busy <= 1'b1; m_n <= 0;
                for (int k = 0; k < NL; k++) begin
                    m_bnd[k]  <= int'(bound_i[k*W +: W]);
                    m_mode[k] <= int'(mode_i[2*k +: 2]);
                end
            end
        end else begin
            m_done <= 1'b0;
            if (en_i) begin
                if (m_n + 1 == m_total()) begin
                    m_busy <= 1'b0; m_done <= 1'b1; m_n <= 0;
                    for (int k = 0; k < NL; k++) m_idle[k] <= seq_val(m_mode[k], m_bnd[k], 0);
                end else begin
                    m_n <= m_n + 1;
                end
            end
        end
    end

    // scoreboard compare, every cycle out of reset
    always @(negedge clk) begin : compare
        int div, len, pos, e_idx, e_last;
        if (rst_ni) begin
            div = 1;
            for (int k = 0; k < NL; k++) begin
                if (m_busy) begin
                    len    = seq_len(m_mode[k], m_bnd[k]);
                    pos    = (m_n / div) % len;
                    e_idx  = seq_val(m_mode[k], m_bnd[k], pos);
                    e_last = (pos == len - 1) ? 1 : 0;
                    div    = div * len;
                end else begin
                    e_idx  = m_idle[k];
                    e_last = 0;
                end
                chk($sformatf("idx%0d", k), int'(idx_o[k*W +: W]), e_idx);
                chk($sformatf("last%0d", k), int'(last_o[k]), e_last);
            end
            chk("busy", int'(busy_o), int'(m_busy));
            chk("done", int'(done_o), int'(m_done));
        end
    end

    // drivers: called at a falling edge, return at a falling edge
    task automatic launch(input logic [NL*W-1:0] b, input logic [2*NL-1:0] m);
        bound_i = b; mode_i = m; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic run(input bit rand_en, input int max_cyc, output int steps, output int busy_cyc);
        bit seen = 1'b0;
        steps = 0; busy_cyc = 0;
        trace.delete(); ltrace.delete();
        for (int c = 0; c < max_cyc && !seen; c++) begin
            en_i = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (busy_o) busy_cyc++;
            if (busy_o && en_i) begin
                steps++;
                trace.push_back(idx_o);
                ltrace.push_back(last_o);
            end
            @(negedge clk);
            if (done_o) seen = 1'b1;
        end
        en_i = 1'b0;
        chk("done_seen", int'(seen), 1);
    endtask

    task automatic check_trace(input string name);
        chk({name, "_len"}, trace.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < trace.size(); i++)
            chk($sformatf("%s[%0d]", name, i), int'(trace[i]), int'(exp_q[i]));
    endtask

    initial begin : stimulus
        int steps, busy_cyc;
        int s2_i0[10] = '{0, 1, 2, 1, 0, 0, 1, 2, 1, 0};

        #1 rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_ni = 1'b1;
        @(negedge clk);
        chk("rst_idx", int'(idx_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_last", int'(last_o), 0);

        // 1: two wrap-up levels B0=2, B1=1
        launch(24'h00_01_02, 6'b00_00_00);
        run(1'b0, 50, steps, busy_cyc);
        chk("s1_steps", steps, 6);
        chk("s1_busy_cycles", busy_cyc, 6);
        exp_q = '{24'h000000, 24'h000001, 24'h000002, 24'h000100, 24'h000101, 24'h000102};
        check_trace("s1_trace");

        // 2: bounce B0=2 inside down B1=1
        launch(24'h00_01_02, 6'b00_01_10);
        run(1'b0, 50, steps, busy_cyc);
        chk("s2_steps", steps, 10);
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back({8'd0, (i < 5) ? 8'd1 : 8'd0, 8'(s2_i0[i])});
        check_trace("s2_trace");
        for (int i = 0; i < 10 && i < ltrace.size(); i++)
            chk($sformatf("s2_last0[%0d]", i), int'(ltrace[i][0]), (i % 5 == 4) ? 1 : 0);
        chk("s2_idle_idx", int'(idx_o), 24'h000100);

        // 3: bounce B0=0 inside wrap-up B1=3
        launch(24'h00_03_00, 6'b00_00_10);
        run(1'b0, 50, steps, busy_cyc);
        chk("s3_steps", steps, 4);
        exp_q = '{24'h000000, 24'h000100, 24'h000200, 24'h000300};
        check_trace("s3_trace");
        for (int i = 0; i < ltrace.size(); i++) chk($sformatf("s3_last0[%0d]", i), int'(ltrace[i][0]), 1);

        // 4: random stalls, reserved mode on level 2 (B2=1), bounds changed mid-run
        launch(24'h01_01_02, 6'b11_01_10);
        bound_i = 24'h05_07_09;
        run(1'b1, 400, steps, busy_cyc);
        chk("s4_steps", steps, 20);

        // 5: second start mid-run ignored, then clear after 3 steps
        launch(24'h00_01_02, 6'b00_00_00);
        en_i = 1'b1; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("s5_idx_at_3", int'(idx_o), 24'h000100);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0; en_i = 1'b0;
        chk("s5_clr_idx", int'(idx_o), 0);
        chk("s5_clr_busy", int'(busy_o), 0);
        chk("s5_clr_done", int'(done_o), 0);
        @(negedge clk);
        chk("s5_no_done", int'(done_o), 0);
        launch(24'h00_01_02, 6'b00_00_00);
        run(1'b0, 50, steps, busy_cyc);
        chk("s5_rerun_steps", steps, 6);

        // 6a: single wrap-up level at B=255, then back-to-back start on the done cycle
        launch(24'h00_00_FF, 6'b00_00_00);
        run(1'b0, 400, steps, busy_cyc);
        chk("s6_steps", steps, 256);
        chk("s6_first", int'(trace[0]), 0);
        chk("s6_last", int'(trace[trace.size()-1]), 255);
        launch(24'h00_01_02, 6'b00_00_00);
        chk("s6_b2b_busy", int'(busy_o), 1);
        run(1'b0, 50, steps, busy_cyc);
        chk("s6_b2b_steps", steps, 6);

        // 6b: asynchronous reset mid-run
        launch(24'h00_01_02, 6'b00_00_00);
        en_i = 1'b1;
        repeat (2) @(negedge clk);
        en_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_idx", int'(idx_o), 0);
        chk("arst_busy", int'(busy_o), 0);
        chk("arst_last", int'(last_o), 0);
        chk("arst_done", int'(done_o), 0);
        @(negedge clk);
        #2 rst_ni = 1'b1;
        @(negedge clk);
        chk("arst_after_done", int'(done_o), 0);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
